// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle divider sequencer.
// Resolves ID/EX/MEM stall requests by depth and redirects the pipeline on exceptions.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        div_start,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_busy,
    output logic [5:0]  div_step,
    output logic        div_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [5:0] LP_LAST_STEP = 6'(DIV_CYCLES - 1);

    localparam logic [5:0] LP_STALL_NONE = 6'b000000;
    localparam logic [5:0] LP_STALL_ID   = 6'b000111;
    localparam logic [5:0] LP_STALL_EX   = 6'b001111;
    localparam logic [5:0] LP_STALL_MEM  = 6'b011111;

    state_t      r_state;
    logic [5:0]  r_step;
    logic        w_ex_req;

    // Divider sequencer: a MEM stall never freezes the iteration count, it only extends DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= 6'd0;
        end else if (excp_req) begin
            r_state <= ST_IDLE;
            r_step  <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_step <= 6'd0;
                    if (div_start) begin
                        r_state <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_step == LP_LAST_STEP) begin
                        r_state <= ST_DONE;
                        r_step  <= 6'd0;
                    end else begin
                        r_state <= ST_BUSY;
                        r_step  <= r_step + 6'd1;
                    end
                end
                ST_DONE: begin
                    r_step <= 6'd0;
                    if (stallreq_mem) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_step  <= 6'd0;
                end
            endcase
        end
    end

    // DONE deliberately does not request an EX hold so EX can consume the result.
    assign w_ex_req = ((r_state == ST_IDLE) && div_start) || (r_state == ST_BUSY);

    // Stall vector: deepest requester wins; reset and exception redirect clear it.
    always_comb begin
        stall = LP_STALL_NONE;
        if (rst || excp_req) begin
            stall = LP_STALL_NONE;
        end else if (stallreq_mem) begin
            stall = LP_STALL_MEM;
        end else if (w_ex_req) begin
            stall = LP_STALL_EX;
        end else if (stallreq_id) begin
            stall = LP_STALL_ID;
        end else begin
            stall = LP_STALL_NONE;
        end
    end

    // Redirect: new_pc is only meaningful with flush and reads zero otherwise.
    always_comb begin
        flush  = 1'b0;
        new_pc = 32'h0000_0000;
        if (!rst && excp_req) begin
            flush  = 1'b1;
            new_pc = excp_pc;
        end else begin
            flush  = 1'b0;
            new_pc = 32'h0000_0000;
        end
    end

    assign div_busy = (r_state == ST_BUSY);
    assign div_done = (r_state == ST_DONE);
    assign div_step = (r_state == ST_BUSY) ? r_step : 6'd0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: per-cycle expectations are queued when
// stimulus is driven and compared when outputs settle mid-cycle.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_mem;
    logic        div_start;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_busy;
    logic [5:0]  div_step;
    logic        div_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic [5:0]  step;
        logic        done;
        logic        chk_st;
    } exp_t;

    exp_t sb_q[$];

    pipe_stall_ctrl #(.DIV_CYCLES(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .div_start    (div_start),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .div_busy     (div_busy),
        .div_step     (div_step),
        .div_done     (div_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] s, input logic f, input logic [31:0] pc,
                                input logic b, input logic [5:0] st, input logic d,
                                input logic cs);
        exp_t e;
        e.stall  = s;
        e.flush  = f;
        e.pc     = pc;
        e.busy   = b;
        e.step   = st;
        e.done   = d;
        e.chk_st = cs;
        return e;
    endfunction

    // One clock cycle: drive at negedge, queue expectation, sample two units later.
    task automatic cyc(input logic r, input logic id, input logic mem, input logic start,
                       input logic ex, input logic [31:0] pc, input exp_t e, input string tag);
        exp_t x;
        @(negedge clk);
        rst          = r;
        stallreq_id  = id;
        stallreq_mem = mem;
        div_start    = start;
        excp_req     = ex;
        excp_pc      = pc;
        sb_q.push_back(e);
        #2;
        x = sb_q.pop_front();
        check({tag, "_stall"}, {26'd0, stall}, {26'd0, x.stall});
        check({tag, "_flush"}, {31'd0, flush}, {31'd0, x.flush});
        check({tag, "_newpc"}, new_pc, x.pc);
        if (x.chk_st) begin
            check({tag, "_busy"}, {31'd0, div_busy}, {31'd0, x.busy});
            check({tag, "_step"}, {26'd0, div_step}, {26'd0, x.step});
            check({tag, "_done"}, {31'd0, div_done}, {31'd0, x.done});
        end
    endtask

    localparam logic [5:0] S0   = 6'b000000;
    localparam logic [5:0] SID  = 6'b000111;
    localparam logic [5:0] SEX  = 6'b001111;
    localparam logic [5:0] SMEM = 6'b011111;

    initial begin
        exp_t z;
        logic m;
        z = mk(S0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1);
        rst = 1'b1; stallreq_id = 1'b0; stallreq_mem = 1'b0;
        div_start = 1'b0; excp_req = 1'b0; excp_pc = 32'h0;
        repeat (2) @(posedge clk);

        // reset overrides every request including the exception
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, z, "rst_ovr");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, mk(SID, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "id_only");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "id_release");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, mk(SMEM, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "id_mem");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A55A5A,
            mk(S0, 1'b1, 32'hA5A55A5A, 1'b0, 6'd0, 1'b0, 1'b1), "excp_ovr");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00001000,
            mk(S0, 1'b1, 32'h00001000, 1'b0, 6'd0, 1'b0, 1'b1), "excp_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "excp_start_idle");

        // full divide, div_start held (ignored) and ID requests masked by EX
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "div_start");
        for (int c = 1; c <= 32; c++) begin
            cyc(1'b0, (c % 2 == 1), 1'b0, 1'b1, 1'b0, 32'h0,
                mk(SEX, 1'b0, 32'h0, 1'b1, 6'(c - 1), 1'b0, 1'b1), "div_busy");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(S0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 1'b1), "div_done");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "div_idle");

        // exception cancels a divide at step 10
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "cx_start");
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                mk(SEX, 1'b0, 32'h0, 1'b1, 6'(c - 1), 1'b0, 1'b1), "cx_busy");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00380,
            mk(S0, 1'b1, 32'hBFC00380, 1'b1, 6'd10, 1'b0, 1'b1), "cx_excp");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "cx_after");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "cx_nodone");

        // MEM stalls during BUSY do not freeze the step; DONE held by MEM
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, mk(SMEM, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "mw_start");
        for (int c = 1; c <= 32; c++) begin
            m = (c >= 5 && c <= 7);
            cyc(1'b0, 1'b0, m, 1'b0, 1'b0, 32'h0,
                mk(m ? SMEM : SEX, 1'b0, 32'h0, 1'b1, 6'(c - 1), 1'b0, 1'b1), "mw_busy");
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                mk(SMEM, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 1'b1), "mw_done_hold");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(S0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 1'b1), "mw_done_rel");

        // back-to-back start accepted from IDLE, then reset at step 5
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "b2b_start");
        for (int c = 1; c <= 5; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                mk(SEX, 1'b0, 32'h0, 1'b1, 6'(c - 1), 1'b0, 1'b1), "b2b_busy");
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, mk(S0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0), "rst_mid");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "rst_after");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "rst_nodone");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1), "re_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b1, 6'd0, 1'b0, 1'b1), "re_step0");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mk(SEX, 1'b0, 32'h0, 1'b1, 6'd1, 1'b0, 1'b1), "re_step1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000180,
            mk(S0, 1'b1, 32'h80000180, 1'b1, 6'd2, 1'b0, 1'b1), "re_excp");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, z, "re_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 32, meaning the number of divider iteration cycles; legal range 2..63.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updated on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port stallreq_id, input, 1 bit: ID hazard (load-use) stall request.
REQ-005 The block SHALL have port stallreq_mem, input, 1 bit: MEM data-SRAM wait request.
REQ-006 The block SHALL have port div_start, input, 1 bit: EX holds a divide; start divider sequencing.
REQ-007 The block SHALL have port excp_req, input, 1 bit: exception/redirect detected in MEM.
REQ-008 The block SHALL have port excp_pc, input, 32 bits: redirect target.
REQ-009 The block SHALL have port stall, output, 6 bits: per-stage hold, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-010 The block SHALL have port flush, output, 1 bit: clear all pipeline registers this edge.
REQ-011 The block SHALL have port new_pc, output, 32 bits: PC to load when flush=1.
REQ-012 The block SHALL have port div_busy, output, 1 bit: divider iterating.
REQ-013 The block SHALL have port div_step, output, 6 bits: current iteration index for the divider datapath.
REQ-014 The block SHALL have port div_done, output, 1 bit: divider result valid, EX may advance.

Function
REQ-015 stall, flush and new_pc SHALL be combinational from inputs and registered FSM state; div_busy, div_step and div_done SHALL be decoded from registered state only.
REQ-016 Stall depth: MEM request -> stall=6'b011111; EX request -> 6'b001111; ID request -> 6'b000111; none -> 6'b000000.
REQ-017 The deepest requesting stage SHALL win when several requests are active together (MEM > EX > ID).
REQ-018 The EX request SHALL be active when (state IDLE and div_start=1) or state BUSY; it SHALL NOT be active in DONE.
REQ-019 excp_req=1 SHALL force flush=1, new_pc=excp_pc, stall=6'b000000 in the same cycle, overriding all stall requests.
REQ-020 flush=0 SHALL imply new_pc=32'h0.
REQ-021 Divider FSM states SHALL be IDLE, BUSY, DONE.
REQ-022 IDLE -> BUSY on div_start=1 and excp_req=0; div_step loads 0.
REQ-023 In BUSY div_step SHALL increment by 1 every cycle, independent of stallreq_mem; at div_step=DIV_CYCLES-1 next state SHALL be DONE.
REQ-024 In DONE div_done=1; DONE SHALL hold while stallreq_mem=1 and SHALL return to IDLE on the first cycle with stallreq_mem=0.
REQ-025 div_start SHALL be ignored in BUSY and DONE.
REQ-026 excp_req=1 in any state SHALL move the FSM to IDLE and clear div_step at the next edge (divide cancelled, no div_done).
REQ-027 div_busy=1 exactly in BUSY; div_step SHALL read 0 outside BUSY.
REQ-028 Without MEM stalls a divide SHALL hold EX for DIV_CYCLES+1 cycles (start cycle plus BUSY), with div_done on the following cycle.
REQ-029 A back-to-back divide SHALL be accepted only from IDLE, i.e. no earlier than one cycle after DONE.

Reset
REQ-030 While rst=1: state IDLE, div_step=0, stall=0, flush=0, new_pc=0, div_busy=0, div_done=0; rst SHALL override excp_req and all requests.
REQ-031 rst asserted mid-divide SHALL abort the divide with no div_done pulse.

Verification
REQ-032 stallreq_id=1 only, one cycle -> stall=6'b000111 that cycle, 0 the next.
REQ-033 stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111.
REQ-034 DIV_CYCLES=32, div_start pulse at cycle 0 -> stall=6'b001111 cycles 0..32, div_busy cycles 1..32 with div_step 0..31, div_done=1 cycle 33, stall=0 cycle 33.
REQ-035 Divide in progress, excp_req=1 with excp_pc=32'hBFC00380 at div_step=10 -> same cycle flush=1, new_pc=32'hBFC00380, stall=0; next cycle div_busy=0, div_step=0, no div_done.
REQ-036 Divide reaches DONE while stallreq_mem=1 for 3 cycles -> div_done held 3 cycles with stall=6'b011111, then 1 more cycle div_done=1 with stall=0, then IDLE.
REQ-037 rst=1 for one cycle at div_step=5 -> next cycle all outputs 0, subsequent div_start restarts at div_step=0.
